// File: rtl/neuron_bus_pkg.sv
// Shared types and command encodings for the neuron command bus scheduler.
package neuron_bus_pkg;

    localparam int NB_ADDR_W = 8;
    localparam int NB_CMD_W  = 8;
    localparam int NB_ARG_W  = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_CONFIG,
        S_RUN,
        S_DONE
    } sched_state_t;

    typedef struct packed {
        logic [NB_ADDR_W-1:0] addr;
        logic [NB_CMD_W-1:0]  cmd;
        logic [NB_ARG_W-1:0]  arg;
    } neuron_cmd_t;

    // Reserved top-of-range codes; weight commands occupy 1..n_inputs.
    function automatic logic [31:0] cmd_nop(input int unsigned cmd_w);
        return (32'd1 << cmd_w) - 32'd1;
    endfunction

    function automatic logic [31:0] cmd_clear(input int unsigned cmd_w);
        return (32'd1 << cmd_w) - 32'd3;
    endfunction

    function automatic logic [31:0] cmd_set_delivery_time(input int unsigned n_inputs);
        return n_inputs + 32'd1;
    endfunction

    function automatic logic [31:0] cmd_set_bias(input int unsigned n_inputs);
        return n_inputs + 32'd2;
    endfunction

endpackage

// File: rtl/neuron_bus_scheduler_fifo.sv
// Synchronous first-word-fall-through FIFO of neuron bus commands.
module neuron_cmd_fifo
    import neuron_bus_pkg::*;
#(
    parameter type T     = neuron_cmd_t,
    parameter int  DEPTH = 16,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  T              push_data_i,
    input  logic          pop_i,
    output T              pop_data_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    T              mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push, do_pop;

    // A push into a full FIFO is legal when a pop frees a slot the same cycle.
    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != FULL_CNT) || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    assign pop_data_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;
    assign full_o     = (count_q == FULL_CNT);
    assign empty_o    = (count_q == '0);

endmodule

// File: rtl/neuron_bus_scheduler.sv
// Sole master of the neuron command bus: buffers host writes, then runs
// clear / config drain / N ticks episodes. NEURON_SCHED_AUTOCLEAR_EN enables the CLEAR cycle.
module neuron_bus_scheduler
    import neuron_bus_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int CMD_WIDTH  = 8,
    parameter int INT_WIDTH  = 8,
    parameter int TICK_WIDTH = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [ADDR_WIDTH-1:0]  wr_addr,
    input  logic [CMD_WIDTH-1:0]   wr_cmd,
    input  logic [2*INT_WIDTH-1:0] wr_arg,
    output logic                   wr_err,
    input  logic                   start,
    input  logic [TICK_WIDTH-1:0]  run_ticks,
    output logic                   busy,
    output logic                   done,
    output logic [TICK_WIDTH-1:0]  tick_count,
    output logic [ADDR_WIDTH-1:0]  addr,
    output logic [CMD_WIDTH-1:0]   cmd,
    output logic [2*INT_WIDTH-1:0] cmd_arg
);

    localparam int FCW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CMD_WIDTH-1:0]  CMD_NOP_C   = CMD_WIDTH'(cmd_nop(CMD_WIDTH));
    localparam logic [CMD_WIDTH-1:0]  CMD_CLEAR_C = CMD_WIDTH'(cmd_clear(CMD_WIDTH));
    localparam logic [FCW-1:0]        CFG_ONE     = FCW'(1);
    localparam logic [TICK_WIDTH-1:0] TICK_ONE    = TICK_WIDTH'(1);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]  addr;
        logic [CMD_WIDTH-1:0]   cmd;
        logic [2*INT_WIDTH-1:0] arg;
    } bus_word_t;

    sched_state_t          state_q, state_d;
    bus_word_t             bus_q, bus_d, fifo_head, wr_word;
    logic [FCW-1:0]        cfg_left_q, cfg_left_d, cfg_src, fifo_count;
    logic [TICK_WIDTH-1:0] ticks_left_q, ticks_left_d, ticks_src;
    logic [TICK_WIDTH-1:0] tick_count_q, tick_count_d;
    logic                  done_q, done_d, wr_err_q;
    logic                  fifo_full, fifo_empty, pop, advance;
    logic                  wr_fire, wr_bad;

    assign wr_fire = wr_valid && wr_ready;
    assign wr_bad  = (wr_cmd == '0) || (wr_cmd == CMD_CLEAR_C) || (wr_cmd == CMD_NOP_C);
    assign wr_word = '{addr: wr_addr, cmd: wr_cmd, arg: wr_arg};

    neuron_cmd_fifo #(
        .T     (bus_word_t),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (wr_fire && !wr_bad),
        .push_data_i (wr_word),
        .pop_i       (pop),
        .pop_data_o  (fifo_head),
        .count_o     (fifo_count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    always_comb begin
        state_d      = state_q;
        cfg_left_d   = cfg_left_q;
        ticks_left_d = ticks_left_q;
        tick_count_d = tick_count_q;
        cfg_src      = cfg_left_q;
        ticks_src    = ticks_left_q;
        bus_d        = '0;
        bus_d.cmd    = CMD_NOP_C;
        done_d       = 1'b0;
        pop          = 1'b0;
        advance      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    tick_count_d = '0;
                    cfg_src      = fifo_count;
                    ticks_src    = run_ticks;
`ifdef NEURON_SCHED_AUTOCLEAR_EN
                    state_d      = S_CLEAR;
                    bus_d.cmd    = CMD_CLEAR_C;
                    cfg_left_d   = fifo_count;
                    ticks_left_d = run_ticks;
`else
                    advance      = 1'b1;
`endif
                end
            end
            S_CLEAR, S_CONFIG, S_RUN: advance = 1'b1;
            default: state_d = S_IDLE;
        endcase

        // Zero-length CONFIG/RUN phases fall straight through to the next one.
        if (advance) begin
            if ((cfg_src != '0) && !fifo_empty) begin
                state_d      = S_CONFIG;
                pop          = 1'b1;
                bus_d        = fifo_head;
                cfg_left_d   = cfg_src - CFG_ONE;
                ticks_left_d = ticks_src;
            end else if (ticks_src != '0) begin
                state_d      = S_RUN;
                bus_d        = '0;
                cfg_left_d   = '0;
                ticks_left_d = ticks_src - TICK_ONE;
                tick_count_d = tick_count_d + TICK_ONE;
            end else begin
                state_d      = S_DONE;
                done_d       = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            bus_q        <= '{addr: '0, cmd: CMD_NOP_C, arg: '0};
            cfg_left_q   <= '0;
            ticks_left_q <= '0;
            tick_count_q <= '0;
            done_q       <= 1'b0;
            wr_err_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            bus_q        <= bus_d;
            cfg_left_q   <= cfg_left_d;
            ticks_left_q <= ticks_left_d;
            tick_count_q <= tick_count_d;
            done_q       <= done_d;
            wr_err_q     <= wr_fire && wr_bad;
        end
    end

    assign wr_ready   = !fifo_full;
    assign wr_err     = wr_err_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;
    assign tick_count = tick_count_q;
    assign addr       = bus_q.addr;
    assign cmd        = bus_q.cmd;
    assign cmd_arg    = bus_q.arg;

endmodule

// File: tb/tb_neuron_bus_scheduler.sv
// Scoreboard bench for neuron_bus_scheduler: episodes are expanded into expected
// bus cycles from a queue model of buffered writes; a negedge monitor checks them.
module tb_neuron_bus_scheduler;

    localparam int FD = 16;
    localparam logic [7:0] NOP = 8'hFF;
    localparam logic [7:0] CLR = 8'hFD;
`ifdef NEURON_SCHED_AUTOCLEAR_EN
    localparam int HAS_CLR = 1;
`else
    localparam int HAS_CLR = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [7:0]  wr_addr = '0;
    logic [7:0]  wr_cmd = '0;
    logic [15:0] wr_arg = '0;
    logic        wr_err;
    logic        start = 1'b0;
    logic [15:0] run_ticks = '0;
    logic        busy, done;
    logic [15:0] tick_count;
    logic [7:0]  addr, cmd;
    logic [15:0] cmd_arg;

    neuron_bus_scheduler dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_cmd(wr_cmd), .wr_arg(wr_arg), .wr_err(wr_err),
        .start(start), .run_ticks(run_ticks), .busy(busy), .done(done),
        .tick_count(tick_count), .addr(addr), .cmd(cmd), .cmd_arg(cmd_arg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  c;
        logic [15:0] g;
        bit          dn;
        bit          cfg;
        logic [15:0] tk;
    } item_t;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  c;
        logic [15:0] g;
    } wr_t;

    item_t       exp_q[$];
    wr_t         mq[$];
    item_t       it;
    bit          model_busy = 0;
    bit          err_exp = 0;
    bit          mon_en = 0;
    logic [15:0] last_ticks = '0;
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic item_t mk(input logic [7:0] a, input logic [7:0] c, input logic [15:0] g,
                                 input bit dn, input bit cfg, input logic [15:0] tk);
        item_t r;
        r.a = a; r.c = c; r.g = g; r.dn = dn; r.cfg = cfg; r.tk = tk;
        return r;
    endfunction

    // Whole episode as seen on the bus: [CLEAR], snapshot of buffered writes, ticks, DONE.
    task automatic plan_episode(input logic [15:0] t);
        model_busy = 1;
        if (HAS_CLR != 0) exp_q.push_back(mk(8'd0, CLR, 16'd0, 1'b0, 1'b0, 16'd0));
        for (int i = 0; i < mq.size(); i++)
            exp_q.push_back(mk(mq[i].a, mq[i].c, mq[i].g, 1'b0, 1'b1, 16'd0));
        for (int k = 1; k <= int'(t); k++)
            exp_q.push_back(mk(8'd0, 8'd0, 16'd0, 1'b0, 1'b0, 16'(k)));
        exp_q.push_back(mk(8'd0, NOP, 16'd0, 1'b1, 1'b0, t));
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("busy", {63'd0, busy}, {63'd0, exp_q.size() != 0});
            if (exp_q.size() != 0) begin
                it = exp_q.pop_front();
                chk("bus", {addr, cmd, cmd_arg, done, tick_count},
                    {it.a, it.c, it.g, it.dn, it.tk});
                if (it.cfg && mq.size() != 0) void'(mq.pop_front());
                if (it.dn) begin
                    model_busy = 0;
                    last_ticks = it.tk;
                end
            end else begin
                chk("idle_bus", {addr, cmd, cmd_arg, done, tick_count},
                    {8'd0, NOP, 16'd0, 1'b0, last_ticks});
            end
            chk("wr_ready", {63'd0, wr_ready}, {63'd0, mq.size() < FD});
            chk("wr_err", {63'd0, wr_err}, {63'd0, err_exp});
        end
    end

    task automatic step();
        bit acc, badc;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            exp_q.delete();
            model_busy = 0;
            err_exp = 0;
            last_ticks = '0;
        end else begin
            acc = wr_valid && (mq.size() < FD);
            badc = (wr_cmd == 8'd0) || (wr_cmd == CLR) || (wr_cmd == NOP);
            err_exp = acc && badc;
            if (start && !model_busy) plan_episode(run_ticks);
            if (acc && !badc) mq.push_back('{wr_addr, wr_cmd, wr_arg});
        end
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] c, input logic [15:0] g);
        wr_valid = 1'b1; wr_addr = a; wr_cmd = c; wr_arg = g;
        step();
        wr_valid = 1'b0;
    endtask

    task automatic go(input logic [15:0] t);
        start = 1'b1; run_ticks = t;
        step();
        start = 1'b0;
    endtask

    function automatic logic [7:0] rnd_cmd();
        logic [7:0] c;
        c = 8'($urandom_range(1, 252));
        if ($urandom_range(0, 7) == 0) begin
            case ($urandom_range(0, 2))
                0: c = 8'd0;
                1: c = CLR;
                default: c = NOP;
            endcase
        end
        return c;
    endfunction

    task automatic wait_idle(input bit noise);
        int n;
        n = 0;
        while ((model_busy || exp_q.size() != 0) && n < 300) begin
            if (noise && $urandom_range(0, 3) == 0) begin
                wr_valid = 1'b1;
                wr_addr = 8'($urandom);
                wr_cmd = rnd_cmd();
                wr_arg = 16'($urandom);
            end
            step();
            wr_valid = 1'b0;
            n++;
        end
        chk("episode_completes", {63'd0, n < 300}, 64'd1);
        step();
    endtask

    initial begin
        repeat (3) step();
        rst = 1'b0;
        mon_en = 1;
        repeat (10) step();

        wr(8'd5, 8'd1, 16'h0080);
        wr(8'd5, 8'd2, 16'h0040);
        wr(8'd5, 8'd4, 16'h0010);
        go(16'd4);
        wait_idle(1'b0);
        chk("ticks_after_ep", {48'd0, tick_count}, 64'd4);

        wr(8'd7, 8'd1, 16'h1111);
        wr(8'd7, 8'd2, 16'h2222);
        go(16'd5);
        repeat (HAS_CLR + 2 + 1) step();
        start = 1'b1; run_ticks = 16'd9;
        wr(8'd7, 8'd3, 16'h3333);
        start = 1'b0;
        wait_idle(1'b0);
        go(16'd1);
        wait_idle(1'b0);

        for (int i = 0; i < FD + 1; i++)
            wr(8'(i), 8'($urandom_range(1, 252)), 16'($urandom));
        chk("full_ready_low", {63'd0, wr_ready}, 64'd0);
        go(16'd2);
        repeat (FD + 4) begin
            wr_valid = 1'b1;
            wr_addr = 8'($urandom);
            wr_cmd = 8'($urandom_range(1, 252));
            wr_arg = 16'($urandom);
            step();
        end
        wr_valid = 1'b0;
        wait_idle(1'b0);
        wr(8'd9, 8'd0, 16'hBEEF);
        wr(8'd9, CLR, 16'hBEEF);
        go(16'd0);
        wait_idle(1'b0);

        go(16'd0);
        wait_idle(1'b0);

        wr(8'd3, 8'd1, 16'h0101);
        go(16'd10);
        repeat (HAS_CLR + 1 + 1) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        go(16'd2);
        wait_idle(1'b0);

        for (int ep = 0; ep < 30; ep++) begin
            for (int w = 0; w < int'($urandom_range(0, 6)); w++)
                wr(8'($urandom), rnd_cmd(), 16'($urandom));
            go(16'($urandom_range(0, 5)));
            wait_idle(1'b1);
        end

        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
